// File: rtl/portal_indication_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : portal_indication_arbiter
// Purpose  : Round-robin arbiter that merges NREQ indication sources into one
//            DEPTH-entry FIFO. The host drains the FIFO through first/deq, and
//            the FIFO head drives the portal interrupt status and channel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req_ENA / req_v     per-source request level and payload (source i at
//                       req_v[i*DATA_W +: DATA_W])
//   req_RDY             one-hot grant; a transfer is ENA & RDY
//   intr_en             interrupt enable (masks intr_status only)
//   ind_first(_RDY)     head payload / FIFO not empty
//   ind_notEmpty(_RDY)  FIFO not empty / constant 1
//   ind_deq_ENA/_RDY    pop the head / FIFO not empty
//   intr_status         intr_en & not empty
//   intr_channel        source index of the head entry, 0 when empty
//   enq_count           total accepted transfers, wraps at 2^32
// ============================================================================
module portal_indication_arbiter #(
  parameter int NREQ   = 4,
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          req_ENA,
  input  logic [NREQ*DATA_W-1:0]   req_v,
  output logic [NREQ-1:0]          req_RDY,
  input  logic                     intr_en,
  output logic                     ind_first_RDY,
  output logic [DATA_W-1:0]        ind_first,
  output logic                     ind_notEmpty_RDY,
  output logic                     ind_notEmpty,
  output logic                     ind_deq_RDY,
  input  logic                     ind_deq_ENA,
  output logic                     intr_status,
  output logic [31:0]              intr_channel,
  output logic [31:0]              enq_count
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [IDX_W:0]   NREQ_E   = (IDX_W+1)'(NREQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [31:0]       enq_count_q;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  src_q  [DEPTH];

  logic              full, empty;
  logic              found;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W:0]    cand_ext;
  logic [IDX_W-1:0]  cand;
  logic              enq, deq;
  logic [DATA_W-1:0] gdata;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // Search starting at rr_ptr and wrapping modulo NREQ. The candidate index
  // is formed one bit wider so the wrap works for non-power-of-2 NREQ.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    cand_ext = '0;
    cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_ext = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_ext >= NREQ_E) begin
        cand_ext = cand_ext - NREQ_E;
      end
      cand = cand_ext[IDX_W-1:0];
      if (!found && req_ENA[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // Grant is computed from registered count only, so a deq while full does
  // not open a slot until the following cycle.
  assign enq     = found && !full && !RST;
  assign deq     = ind_deq_ENA && !empty && !RST;
  assign req_RDY = enq ? (NREQ'(1) << gidx) : '0;
  assign gdata   = req_v[gidx*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (enq) begin
      rr_ptr_d = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rr_ptr_q    <= '0;
      enq_count_q <= '0;
    end else begin
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      if (enq) begin
        wr_ptr_q    <= wr_ptr_q + 1'b1;
        enq_count_q <= enq_count_q + 32'd1;
      end
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge CLK) begin
    if (enq) begin
      data_q[wr_ptr_q] <= gdata;
      src_q[wr_ptr_q]  <= gidx;
    end
  end

  assign ind_first        = data_q[rd_ptr_q];
  assign ind_first_RDY    = !empty;
  assign ind_notEmpty     = !empty;
  assign ind_notEmpty_RDY = 1'b1;
  assign ind_deq_RDY      = !empty;
  assign intr_status      = intr_en && !empty;
  assign intr_channel     = empty ? 32'd0 : 32'(src_q[rd_ptr_q]);
  assign enq_count        = enq_count_q;

endmodule
`default_nettype wire
